// File: rtl/cluster_rate_monitor.sv
// Windowed cluster-rate statistics: saturating sum, peak and overflow count per
// WINDOW_BX crossings, handed to slow control through a rdy/ack snapshot.
module cluster_rate_monitor #(
    parameter int unsigned WINDOW_BX = 1024,
    parameter int unsigned SUM_W     = 21
) (
    input  logic             clock4x,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             bx_strobe_i,
    input  logic [10:0]      cnt_i,
    input  logic             overflow_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [10:0]      peak_o,
    output logic [15:0]      ovf_bx_o,
    output logic             rdy_o,
    input  logic             ack_i,
    output logic             lost_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [10:0]      r_cnt_s1;
    logic             r_stb_s1;
    logic [SUM_W-1:0] r_acc_sum;
    logic [10:0]      r_acc_peak;
    logic [15:0]      r_acc_ovf;
    logic [15:0]      r_nbx;

    logic             w_take;
    logic             w_last;
    logic [SUM_W:0]   w_sum_ext;
    logic [SUM_W-1:0] w_sum_nxt;
    logic [10:0]      w_peak_nxt;
    logic [16:0]      w_ovf_ext;
    logic [15:0]      w_ovf_nxt;

    // overflow_i lags cnt_i by one cycle, so it pairs with the S1 sample
    always_comb begin
        w_take     = (r_state == RUN) && en_i && r_stb_s1;
        w_last     = w_take && (r_nbx == 16'(WINDOW_BX - 1));
        w_sum_ext  = {1'b0, r_acc_sum} + (SUM_W + 1)'(r_cnt_s1);
        w_sum_nxt  = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
        w_peak_nxt = (r_cnt_s1 > r_acc_peak) ? r_cnt_s1 : r_acc_peak;
        w_ovf_ext  = {1'b0, r_acc_ovf} + 17'(overflow_i);
        w_ovf_nxt  = w_ovf_ext[16] ? '1 : w_ovf_ext[15:0];
    end

    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt_s1   <= '0;
            r_stb_s1   <= 1'b0;
            r_acc_sum  <= '0;
            r_acc_peak <= '0;
            r_acc_ovf  <= '0;
            r_nbx      <= '0;
            sum_o      <= '0;
            peak_o     <= '0;
            ovf_bx_o   <= '0;
            rdy_o      <= 1'b0;
            lost_o     <= 1'b0;
        end else if (clr_i) begin
            r_state    <= en_i ? RUN : IDLE;
            r_cnt_s1   <= '0;
            r_stb_s1   <= 1'b0;
            r_acc_sum  <= '0;
            r_acc_peak <= '0;
            r_acc_ovf  <= '0;
            r_nbx      <= '0;
            rdy_o      <= 1'b0;
            lost_o     <= 1'b0;
        end else begin
            r_cnt_s1 <= cnt_i;
            r_stb_s1 <= bx_strobe_i;

            case (r_state)
                IDLE:    if (en_i)  r_state <= RUN;
                RUN:     if (!en_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Outside an enabled RUN cycle the partial window is discarded
            if ((r_state != RUN) || !en_i) begin
                r_acc_sum  <= '0;
                r_acc_peak <= '0;
                r_acc_ovf  <= '0;
                r_nbx      <= '0;
            end else if (w_last) begin
                sum_o      <= w_sum_nxt;
                peak_o     <= w_peak_nxt;
                ovf_bx_o   <= w_ovf_nxt;
                r_acc_sum  <= '0;
                r_acc_peak <= '0;
                r_acc_ovf  <= '0;
                r_nbx      <= '0;
            end else if (w_take) begin
                r_acc_sum  <= w_sum_nxt;
                r_acc_peak <= w_peak_nxt;
                r_acc_ovf  <= w_ovf_nxt;
                r_nbx      <= r_nbx + 16'd1;
            end

            // Window completion wins over a simultaneous ack
            if (w_last) begin
                rdy_o <= 1'b1;
                if (rdy_o && !ack_i) lost_o <= 1'b1;
            end else if (rdy_o && ack_i) begin
                rdy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// Directed bench for cluster_rate_monitor: WINDOW_BX=4 with SUM_W=21 and SUM_W=12.
module tb_cluster_rate_monitor;

    logic        clk = 1'b0;
    logic        reset, en, clr, stb, ovf, ack;
    logic [10:0] cnt;

    logic [20:0] sum_a;
    logic [10:0] peak_a;
    logic [15:0] ovfbx_a;
    logic        rdy_a, lost_a;

    logic [11:0] sum_b;
    logic [10:0] peak_b;
    logic [15:0] ovfbx_b;
    logic        rdy_b, lost_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cluster_rate_monitor #(.WINDOW_BX(4), .SUM_W(21)) dut (
        .clock4x(clk), .reset(reset), .en_i(en), .clr_i(clr),
        .bx_strobe_i(stb), .cnt_i(cnt), .overflow_i(ovf),
        .sum_o(sum_a), .peak_o(peak_a), .ovf_bx_o(ovfbx_a),
        .rdy_o(rdy_a), .ack_i(ack), .lost_o(lost_a)
    );

    cluster_rate_monitor #(.WINDOW_BX(4), .SUM_W(12)) dut_s (
        .clock4x(clk), .reset(reset), .en_i(en), .clr_i(clr),
        .bx_strobe_i(stb), .cnt_i(cnt), .overflow_i(ovf),
        .sum_o(sum_b), .peak_o(peak_b), .ovf_bx_o(ovfbx_b),
        .rdy_o(rdy_b), .ack_i(ack), .lost_o(lost_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Strobe, then overflow/ack in the following cycle, then two idle cycles
    task automatic send(input logic [10:0] c, input logic ov, input logic ak);
        cnt = c; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; ovf = ov; ack = ak;
        @(negedge clk);
        ovf = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; stb = 1'b0; ovf = 1'b0; ack = 1'b0; cnt = '0;
        repeat (2) @(negedge clk);
        check("reset_sum", 32'(sum_a), 0);
        check("reset_rdy", 32'(rdy_a), 0);
        reset = 1'b0;

        // Disabled: strobes ignored
        for (int i = 0; i < 4; i++) send(11'd9, 1'b1, 1'b0);
        check("idle_rdy", 32'(rdy_a), 0);
        check("idle_rdy_s", 32'(rdy_b), 0);
        check("idle_sum", 32'(sum_a), 0);

        // Basic window
        en = 1'b1;
        @(negedge clk);
        send(11'd3, 1'b0, 1'b0);
        send(11'd10, 1'b1, 1'b0);
        send(11'd0, 1'b0, 1'b0);
        send(11'd7, 1'b0, 1'b0);
        check("basic_sum", 32'(sum_a), 20);
        check("basic_peak", 32'(peak_a), 10);
        check("basic_ovf", 32'(ovfbx_a), 1);
        check("basic_rdy", 32'(rdy_a), 1);
        pulse_ack();
        check("ack_rdy", 32'(rdy_a), 0);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check("async_sum", 32'(sum_a), 0);
        check("async_peak", 32'(peak_a), 0);
        check("async_ovf", 32'(ovfbx_a), 0);
        check("async_rdy", 32'(rdy_a), 0);
        check("async_lost", 32'(lost_a), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Saturation
        for (int i = 0; i < 4; i++) send(11'd1536, 1'b0, 1'b0);
        check("sat_sum12", 32'(sum_b), 4095);
        check("sat_peak12", 32'(peak_b), 1536);
        check("sat_sum21", 32'(sum_a), 6144);
        pulse_ack();

        // Lost snapshot
        for (int i = 0; i < 4; i++) send(11'd1, 1'b0, 1'b0);
        check("w1_sum", 32'(sum_a), 4);
        check("w1_lost", 32'(lost_a), 0);
        for (int i = 0; i < 4; i++) send(11'd2, 1'b0, 1'b0);
        check("lost_sum", 32'(sum_a), 8);
        check("lost_rdy", 32'(rdy_a), 1);
        check("lost_flag", 32'(lost_a), 1);

        // Clear
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_rdy", 32'(rdy_a), 0);
        check("clr_lost", 32'(lost_a), 0);
        check("clr_sum", 32'(sum_a), 8);

        // Ack colliding with completion
        for (int i = 0; i < 4; i++) send(11'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(11'd2, 1'b0, 1'b0);
        send(11'd2, 1'b0, 1'b1);
        check("coll_lost", 32'(lost_a), 0);
        check("coll_rdy", 32'(rdy_a), 1);
        check("coll_sum", 32'(sum_a), 8);

        // Back-to-back strobes
        pulse_ack();
        for (int i = 0; i < 8; i++) begin
            cnt = 11'(i); stb = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                check("b2b_sum1", 32'(sum_a), 6);
                check("b2b_rdy1", 32'(rdy_a), 1);
            end
        end
        stb = 1'b0;
        @(negedge clk);
        check("b2b_sum2", 32'(sum_a), 22);
        check("b2b_peak2", 32'(peak_a), 7);
        check("b2b_lost", 32'(lost_a), 1);

        // Enable drop mid-window
        send(11'd5, 1'b0, 1'b0);
        send(11'd5, 1'b0, 1'b0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(11'd1, 1'b0, 1'b0);
        check("endrop_sum", 32'(sum_a), 4);
        check("endrop_peak", 32'(peak_a), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
